// File: rtl/mem_mpu_regions_if.sv
// rtl/mem_mpu_regions_if.sv - CPU/SRAM bus bundle for the memory protection unit
// Purpose: groups the picorv32 native memory port, the SRAM port and the MPU
// status outputs into one bundle.
// Ports (modports):
//   master - CPU + SRAM side: drives cpu_valid/cpu_instr/cpu_addr/cpu_wdata/
//            cpu_wstrb and mem_rdata; observes everything else.
//   slave  - MPU side: drives cpu_ready/cpu_rdata, inform_cpu_wait, interrupt,
//            fault_addr/fault_cause and mem_wen/mem_addr/mem_wdata.
interface mem_mpu_regions_if #(
  parameter int ADDR_WIDTH = 22
);
  logic                  cpu_valid;
  logic                  cpu_instr;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [31:0]           cpu_wdata;
  logic [3:0]            cpu_wstrb;
  logic                  cpu_ready;
  logic [31:0]           cpu_rdata;
  logic                  inform_cpu_wait;
  logic                  interrupt;
  logic [ADDR_WIDTH-1:0] fault_addr;
  logic [1:0]            fault_cause;
  logic [3:0]            mem_wen;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;

  modport master (
    output cpu_valid, cpu_instr, cpu_addr, cpu_wdata, cpu_wstrb, mem_rdata,
    input  cpu_ready, cpu_rdata, inform_cpu_wait, interrupt, fault_addr,
           fault_cause, mem_wen, mem_addr, mem_wdata
  );

  modport slave (
    input  cpu_valid, cpu_instr, cpu_addr, cpu_wdata, cpu_wstrb, mem_rdata,
    output cpu_ready, cpu_rdata, inform_cpu_wait, interrupt, fault_addr,
           fault_cause, mem_wen, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_mpu_regions.sv
// rtl/mem_mpu_regions.sv - region-based memory protection unit for picorv32 SRAM
// Purpose: loads NUM_REGIONS descriptors from SRAM after reset, then checks each
// CPU fetch/read/write against them; permitted accesses go to SRAM, violations
// complete with zero data, pulse interrupt and latch fault_addr/fault_cause.
// Ports:
//   clk    - clock
//   resetn - asynchronous active-low reset
//   bus    - mem_mpu_regions_if.slave (CPU request/response, SRAM port, status)
// Optional feature macro: MPU_CONF_LOCK_EN - writes into the descriptor table
// fault with cause 3 regardless of region permissions.
module mem_mpu_regions #(
  parameter int ADDR_WIDTH  = 22,
  parameter int NUM_REGIONS = 4,
  parameter int CONF_BASE   = 768
) (
  input logic              clk,
  input logic              resetn,
  mem_mpu_regions_if.slave bus
);
  localparam int                    NUM_WORDS   = 2 * NUM_REGIONS;
  localparam logic [5:0]            LAST_CNT    = 6'(NUM_WORDS + 1);
  localparam logic [ADDR_WIDTH-1:0] TABLE_FIRST = ADDR_WIDTH'(CONF_BASE);

  typedef enum logic [2:0] {S_LOAD, S_IDLE, S_ACCESS, S_RESP, S_FAULT} state_t;

  state_t                state_q, state_d;
  logic [5:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] base_q  [NUM_REGIONS];
  logic [ADDR_WIDTH-1:0] base_d  [NUM_REGIONS];
  logic [ADDR_WIDTH-1:0] limit_q [NUM_REGIONS];
  logic [ADDR_WIDTH-1:0] limit_d [NUM_REGIONS];
  logic [3:0]            flags_q [NUM_REGIONS];  // {X, W, R, enable} = word1[31:28]
  logic [3:0]            flags_d [NUM_REGIONS];
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [1:0]            req_cause_q, req_cause_d;
  logic                  ready_q, ready_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  wait_q, wait_d;
  logic                  intr_q, intr_d;
  logic [ADDR_WIDTH-1:0] fault_addr_q, fault_addr_d;
  logic [1:0]            fault_cause_q, fault_cause_d;
  logic [3:0]            mem_wen_q, mem_wen_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;

  logic       hit;
  logic [3:0] hit_flags;
  logic       perm_ok;
  logic       is_write;
  logic [1:0] check_cause;
  logic [5:0] widx;
  logic       unused_rdata;

  // Table word captured this cycle: data for the address issued two edges ago.
  assign widx         = cnt_q - 6'd2;
  assign unused_rdata = ^bus.mem_rdata;

  // A fetch with stray strobes is still a fetch and never writes.
  assign is_write = !bus.cpu_instr && (bus.cpu_wstrb != 4'b0);

  // Scan from the top so the lowest-index hit is the one left standing.
  always_comb begin
    hit       = 1'b0;
    hit_flags = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (flags_q[i][0] && (bus.cpu_addr >= base_q[i]) && (bus.cpu_addr <= limit_q[i])) begin
        hit       = 1'b1;
        hit_flags = flags_q[i];
      end
    end
  end

  always_comb begin
    if (bus.cpu_instr)  perm_ok = hit_flags[3];
    else if (is_write)  perm_ok = hit_flags[2];
    else                perm_ok = hit_flags[1];
  end

`ifdef MPU_CONF_LOCK_EN
  localparam logic [ADDR_WIDTH-1:0] TABLE_LAST = ADDR_WIDTH'(CONF_BASE + NUM_WORDS - 1);
  logic in_table;
  assign in_table = (bus.cpu_addr >= TABLE_FIRST) && (bus.cpu_addr <= TABLE_LAST);
`endif

  always_comb begin
    check_cause = 2'd0;
    if (!hit)          check_cause = 2'd1;
    else if (!perm_ok) check_cause = 2'd2;
`ifdef MPU_CONF_LOCK_EN
    // Table lock overrides whatever the regions would allow.
    if (is_write && in_table) check_cause = 2'd3;
`endif
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    base_d        = base_q;
    limit_d       = limit_q;
    flags_d       = flags_q;
    req_addr_d    = req_addr_q;
    req_cause_d   = req_cause_q;
    ready_d       = 1'b0;
    rdata_d       = '0;
    wait_d        = wait_q;
    intr_d        = 1'b0;
    fault_addr_d  = fault_addr_q;
    fault_cause_d = fault_cause_q;
    mem_wen_d     = 4'b0;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;

    case (state_q)
      S_LOAD: begin
        if (cnt_q < 6'(NUM_WORDS)) mem_addr_d = TABLE_FIRST + ADDR_WIDTH'(cnt_q);
        if (cnt_q >= 6'd2) begin
          for (int i = 0; i < NUM_REGIONS; i++) begin
            if (widx[5:1] == 5'(i)) begin
              if (widx[0]) begin
                limit_d[i] = bus.mem_rdata[ADDR_WIDTH-1:0];
                flags_d[i] = bus.mem_rdata[31:28];
              end else begin
                base_d[i]  = bus.mem_rdata[ADDR_WIDTH-1:0];
              end
            end
          end
        end
        if (cnt_q == LAST_CNT) begin
          state_d = S_IDLE;
          wait_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      S_IDLE: begin
        if (bus.cpu_valid) begin
          req_addr_d  = bus.cpu_addr;
          req_cause_d = check_cause;
          if (check_cause == 2'd0) begin
            mem_addr_d  = bus.cpu_addr;
            mem_wdata_d = bus.cpu_wdata;
            mem_wen_d   = is_write ? bus.cpu_wstrb : 4'b0;
            state_d     = S_ACCESS;
          end else begin
            state_d = S_FAULT;
          end
        end
      end
      S_ACCESS: state_d = S_RESP;
      S_RESP: begin
        ready_d = 1'b1;
        rdata_d = bus.mem_rdata;
        state_d = S_IDLE;
      end
      S_FAULT: begin
        ready_d       = 1'b1;
        intr_d        = 1'b1;
        fault_addr_d  = req_addr_q;
        fault_cause_d = req_cause_q;
        state_d       = S_IDLE;
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_LOAD;
      cnt_q         <= '0;
      for (int i = 0; i < NUM_REGIONS; i++) begin
        base_q[i]  <= '0;
        limit_q[i] <= '0;
        flags_q[i] <= '0;
      end
      req_addr_q    <= '0;
      req_cause_q   <= '0;
      ready_q       <= 1'b0;
      rdata_q       <= '0;
      wait_q        <= 1'b1;
      intr_q        <= 1'b0;
      fault_addr_q  <= '0;
      fault_cause_q <= '0;
      mem_wen_q     <= '0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      base_q        <= base_d;
      limit_q       <= limit_d;
      flags_q       <= flags_d;
      req_addr_q    <= req_addr_d;
      req_cause_q   <= req_cause_d;
      ready_q       <= ready_d;
      rdata_q       <= rdata_d;
      wait_q        <= wait_d;
      intr_q        <= intr_d;
      fault_addr_q  <= fault_addr_d;
      fault_cause_q <= fault_cause_d;
      mem_wen_q     <= mem_wen_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  assign bus.cpu_ready       = ready_q;
  assign bus.cpu_rdata       = rdata_q;
  assign bus.inform_cpu_wait = wait_q;
  assign bus.interrupt       = intr_q;
  assign bus.fault_addr      = fault_addr_q;
  assign bus.fault_cause     = fault_cause_q;
  assign bus.mem_wen         = mem_wen_q;
  assign bus.mem_addr        = mem_addr_q;
  assign bus.mem_wdata       = mem_wdata_q;
endmodule

// File: tb/tb_mem_mpu_regions.sv
// tb/tb_mem_mpu_regions.sv - self-checking bench for mem_mpu_regions
module tb_mem_mpu_regions;
  logic clk = 1'b0;
  logic resetn;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        chk_rdata;
    logic        intr;
    int          edges;
  } exp_t;
  exp_t sb[$];

  mem_mpu_regions_if #(.ADDR_WIDTH(22)) bus();

  mem_mpu_regions #(.ADDR_WIDTH(22), .NUM_REGIONS(4), .CONF_BASE(768)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // SRAM: synchronous read, byte-lane writes; filled on the first edge.
  logic [31:0] sram [0:1023];
  logic        init_done = 1'b0;
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 1024; i++) sram[i] <= 32'h1111_0000 | 32'(i);
      sram[10'h010] <= 32'h0000_0013;
      sram[10'h300] <= 32'h0000_0000;  sram[10'h301] <= 32'hF000_00FF;  // R0 RWX
      sram[10'h302] <= 32'h0000_0200;  sram[10'h303] <= 32'h9000_02FF;  // R1 X
      sram[10'h304] <= 32'h0000_0300;  sram[10'h305] <= 32'h7000_03FF;  // R2 RW
      sram[10'h306] <= 32'h0000_0080;  sram[10'h307] <= 32'h2000_00FF;  // R3 R, disabled
      init_done <= 1'b1;
    end else begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_wen[b]) sram[bus.mem_addr[9:0]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    end
    bus.mem_rdata <= sram[bus.mem_addr[9:0]];
  end

  // Drives one request from IDLE, records the expectation, waits (bounded) for cpu_ready.
  task automatic run_req(input logic instr, input logic [21:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic [31:0] exp_rdata, input logic chk_rdata,
                         input logic exp_intr, input int exp_edges,
                         output int edges, output logic [31:0] rdata, output logic intr,
                         output logic [3:0] wen_seen);
    exp_t e;
    @(posedge clk); #1;
    bus.cpu_valid = 1'b1; bus.cpu_instr = instr; bus.cpu_addr = addr;
    bus.cpu_wdata = wdata; bus.cpu_wstrb = wstrb;
    e.rdata = exp_rdata; e.chk_rdata = chk_rdata; e.intr = exp_intr; e.edges = exp_edges;
    sb.push_back(e);
    edges = 0; wen_seen = 4'h0;
    do begin
      @(posedge clk); #1;
      edges++;
      wen_seen |= bus.mem_wen;
    end while (!bus.cpu_ready && edges < 40);
    rdata = bus.cpu_rdata; intr = bus.interrupt;
    bus.cpu_valid = 1'b0; bus.cpu_instr = 1'b0; bus.cpu_wstrb = 4'h0;
  endtask

  task automatic test_reset_and_load();
    logic [116:0] got;
    int n;
    logic saw_ready;
    exp_t e;
    resetn = 1'b0;
    repeat (3) @(posedge clk); #1;
    got = {bus.inform_cpu_wait, bus.cpu_ready, bus.interrupt, bus.fault_cause, bus.fault_addr,
           bus.mem_wen, bus.mem_addr, bus.mem_wdata, bus.cpu_rdata};
    checks++;
    if (got !== {1'b1, 116'd0}) begin
      errors++; $display("FAIL reset_values: got %h want %h", got, {1'b1, 116'd0});
    end
    // Fetch presented while the table loads: must be held until IDLE.
    @(negedge clk);
    bus.cpu_valid = 1'b1; bus.cpu_instr = 1'b1; bus.cpu_addr = 22'h010; bus.cpu_wstrb = 4'h0;
    resetn = 1'b1;
    e.rdata = 32'h13; e.chk_rdata = 1'b1; e.intr = 1'b0; e.edges = 3;
    sb.push_back(e);
    @(posedge clk);
    n = 0; saw_ready = 1'b0;
    do begin
      @(posedge clk); #1; n++;
      if (bus.cpu_ready) saw_ready = 1'b1;
    end while (bus.inform_cpu_wait && n < 50);
    checks++;
    if (n !== 9) begin errors++; $display("FAIL load_cycles: got %0d cycles want 9", n); end
    checks++;
    if (saw_ready !== 1'b0) begin errors++; $display("FAIL held_during_load: ready seen during load"); end
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!bus.cpu_ready && n < 40);
    e = sb.pop_front();
    checks++;
    if (n !== e.edges) begin errors++; $display("FAIL held_fetch_latency: got %0d want %0d", n, e.edges); end
    checks++;
    if (bus.cpu_rdata !== e.rdata) begin
      errors++; $display("FAIL held_fetch_rdata: got %h want %h", bus.cpu_rdata, e.rdata);
    end
    checks++;
    if (bus.interrupt !== e.intr) begin errors++; $display("FAIL held_fetch_intr: got %b want %b", bus.interrupt, e.intr); end
    bus.cpu_valid = 1'b0; bus.cpu_instr = 1'b0;
  endtask

  task automatic test_fetch();
    int edges; logic [31:0] rd; logic intr; logic [3:0] wen; exp_t e;
    run_req(1'b1, 22'h010, 32'h0, 4'h0, 32'h13, 1'b1, 1'b0, 3, edges, rd, intr, wen);
    e = sb.pop_front();
    checks++;
    if (edges !== e.edges) begin errors++; $display("FAIL fetch_latency: got %0d want %0d", edges, e.edges); end
    checks++;
    if (rd !== e.rdata) begin errors++; $display("FAIL fetch_rdata: got %h want %h", rd, e.rdata); end
    checks++;
    if (intr !== e.intr) begin errors++; $display("FAIL fetch_intr: got %b want %b", intr, e.intr); end
    @(posedge clk); #1;
    checks++;
    if (bus.cpu_ready !== 1'b0) begin errors++; $display("FAIL fetch_ready_pulse: got %b want 0", bus.cpu_ready); end
  endtask

  task automatic test_blocked_write();
    int edges; logic [31:0] rd; logic intr; logic [3:0] wen; exp_t e;
    run_req(1'b0, 22'h250, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b1, 1'b1, 2, edges, rd, intr, wen);
    e = sb.pop_front();
    checks++;
    if (edges !== e.edges) begin errors++; $display("FAIL perm_fault_latency: got %0d want %0d", edges, e.edges); end
    checks++;
    if (rd !== e.rdata) begin errors++; $display("FAIL perm_fault_rdata: got %h want %h", rd, e.rdata); end
    checks++;
    if (intr !== e.intr) begin errors++; $display("FAIL perm_fault_intr: got %b want %b", intr, e.intr); end
    checks++;
    if (wen !== 4'h0) begin errors++; $display("FAIL perm_fault_wen: got %h want 0", wen); end
    checks++;
    if (bus.fault_addr !== 22'h250) begin errors++; $display("FAIL perm_fault_addr: got %h want 250", bus.fault_addr); end
    checks++;
    if (bus.fault_cause !== 2'd2) begin errors++; $display("FAIL perm_fault_cause: got %0d want 2", bus.fault_cause); end
    @(posedge clk); #1;
    checks++;
    if (bus.interrupt !== 1'b0) begin errors++; $display("FAIL intr_pulse: got %b want 0", bus.interrupt); end
    checks++;
    if (sram[10'h250] !== 32'h1111_0250) begin
      errors++; $display("FAIL blocked_write_sram: got %h want 11110250", sram[10'h250]);
    end
  endtask

  task automatic test_no_region();
    int edges; logic [31:0] rd; logic intr; logic [3:0] wen; exp_t e;
    run_req(1'b0, 22'h150, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1, 2, edges, rd, intr, wen);
    e = sb.pop_front();
    checks++;
    if (edges !== e.edges || intr !== e.intr || rd !== e.rdata) begin
      errors++; $display("FAIL noregion_resp: got edges=%0d intr=%b rdata=%h want %0d %b %h", edges, intr, rd, e.edges, e.intr, e.rdata);
    end
    checks++;
    if (bus.fault_cause !== 2'd1) begin errors++; $display("FAIL noregion_cause: got %0d want 1", bus.fault_cause); end
    run_req(1'b0, 22'h0FF, 32'h0, 4'h0, 32'h1111_00FF, 1'b1, 1'b0, 3, edges, rd, intr, wen);
    e = sb.pop_front();
    checks++;
    if (edges !== e.edges) begin errors++; $display("FAIL limit_read_latency: got %0d want %0d", edges, e.edges); end
    checks++;
    if (rd !== e.rdata) begin errors++; $display("FAIL limit_read_rdata: got %h want %h", rd, e.rdata); end
    checks++;
    if (intr !== e.intr) begin errors++; $display("FAIL limit_read_intr: got %b want %b", intr, e.intr); end
    checks++;
    if (bus.fault_addr !== 22'h150 || bus.fault_cause !== 2'd1) begin
      errors++; $display("FAIL fault_hold: got addr=%h cause=%0d want 150 1", bus.fault_addr, bus.fault_cause);
    end
  endtask

  task automatic test_overlap();
    int edges; logic [31:0] rd; logic intr; logic [3:0] wen; exp_t e;
    run_req(1'b0, 22'h0C0, 32'hA5A5_A5A5, 4'hF, 32'h0, 1'b0, 1'b0, 3, edges, rd, intr, wen);
    e = sb.pop_front();
    checks++;
    if (edges !== e.edges || intr !== e.intr) begin
      errors++; $display("FAIL overlap_write_resp: got edges=%0d intr=%b want %0d %b", edges, intr, e.edges, e.intr);
    end
    checks++;
    if (wen !== 4'hF) begin errors++; $display("FAIL overlap_write_wen: got %h want f", wen); end
    checks++;
    if (sram[10'h0C0] !== 32'hA5A5_A5A5) begin errors++; $display("FAIL overlap_write_sram: got %h want a5a5a5a5", sram[10'h0C0]); end
    run_req(1'b0, 22'h0C0, 32'h0, 4'h0, 32'hA5A5_A5A5, 1'b1, 1'b0, 3, edges, rd, intr, wen);
    e = sb.pop_front();
    checks++;
    if (e.chk_rdata && rd !== e.rdata) begin errors++; $display("FAIL overlap_readback: got %h want %h", rd, e.rdata); end
    checks++;
    if (edges !== e.edges) begin errors++; $display("FAIL overlap_read_latency: got %0d want %0d", edges, e.edges); end
  endtask

  task automatic test_reset_mid_access();
    int n;
    @(posedge clk); #1;
    bus.cpu_valid = 1'b1; bus.cpu_instr = 1'b0; bus.cpu_addr = 22'h310;
    bus.cpu_wdata = 32'hCAFE_F00D; bus.cpu_wstrb = 4'hF;
    @(posedge clk); #1;
    checks++;
    if (bus.mem_wen !== 4'hF) begin errors++; $display("FAIL midreset_access_started: got %h want f", bus.mem_wen); end
    resetn = 1'b0; #1;
    checks++;
    if (bus.mem_wen !== 4'h0 || bus.mem_addr !== 22'h0 || bus.inform_cpu_wait !== 1'b1) begin
      errors++; $display("FAIL midreset_outputs: got wen=%h addr=%h wait=%b want 0 0 1", bus.mem_wen, bus.mem_addr, bus.inform_cpu_wait);
    end
    bus.cpu_valid = 1'b0; bus.cpu_wstrb = 4'h0;
    repeat (2) @(posedge clk); #1;
    checks++;
    if (sram[10'h310] !== 32'h1111_0310) begin errors++; $display("FAIL midreset_write_abandoned: got %h want 11110310", sram[10'h310]); end
    @(negedge clk); resetn = 1'b1;
    @(posedge clk);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (bus.inform_cpu_wait && n < 50);
    checks++;
    if (n !== 9) begin errors++; $display("FAIL reload_cycles: got %0d want 9", n); end
  endtask

  task automatic test_conf_lock();
    int edges; logic [31:0] rd; logic intr; logic [3:0] wen; exp_t e;
`ifdef MPU_CONF_LOCK_EN
    run_req(1'b0, 22'h300, 32'h1234_5678, 4'hF, 32'h0, 1'b1, 1'b1, 2, edges, rd, intr, wen);
    e = sb.pop_front();
    checks++;
    if (edges !== e.edges || intr !== e.intr || rd !== e.rdata) begin
      errors++; $display("FAIL lock_resp: got edges=%0d intr=%b rdata=%h want %0d %b %h", edges, intr, rd, e.edges, e.intr, e.rdata);
    end
    checks++;
    if (bus.fault_cause !== 2'd3 || bus.fault_addr !== 22'h300) begin
      errors++; $display("FAIL lock_cause: got cause=%0d addr=%h want 3 300", bus.fault_cause, bus.fault_addr);
    end
    checks++;
    if (sram[10'h300] !== 32'h0 || wen !== 4'h0) begin
      errors++; $display("FAIL lock_sram: got %h wen=%h want 0 0", sram[10'h300], wen);
    end
`else
    run_req(1'b0, 22'h300, 32'h1234_5678, 4'hF, 32'h0, 1'b0, 1'b0, 3, edges, rd, intr, wen);
    e = sb.pop_front();
    checks++;
    if (edges !== e.edges || intr !== e.intr) begin
      errors++; $display("FAIL table_write_resp: got edges=%0d intr=%b want %0d %b", edges, intr, e.edges, e.intr);
    end
    checks++;
    if (sram[10'h300] !== 32'h1234_5678) begin errors++; $display("FAIL table_write_sram: got %h want 12345678", sram[10'h300]); end
`endif
    // A changed descriptor word must not affect the loaded regions.
    run_req(1'b1, 22'h010, 32'h0, 4'h0, 32'h13, 1'b1, 1'b0, 3, edges, rd, intr, wen);
    e = sb.pop_front();
    checks++;
    if (edges !== e.edges || rd !== e.rdata || intr !== e.intr) begin
      errors++; $display("FAIL table_runtime_change: got edges=%0d rdata=%h intr=%b want %0d %h %b", edges, rd, intr, e.edges, e.rdata, e.intr);
    end
  endtask

  initial begin
    resetn        = 1'b0;
    bus.cpu_valid = 1'b0;
    bus.cpu_instr = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.cpu_wstrb = '0;
    test_reset_and_load();
    test_fetch();
    test_blocked_write();
    test_no_region();
    test_overlap();
    test_reset_mid_access();
    test_conf_lock();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_mpu_regions.md
# mem_mpu_regions

Parametrised memory protection unit between the picorv32 native memory port and the on-chip SRAM. After reset it loads `NUM_REGIONS` region descriptors from a configuration table in SRAM, then checks every CPU fetch, read and write against those regions. Permitted accesses are forwarded to SRAM. Violating accesses are blocked, completed with zero data, and reported by a one-cycle interrupt pulse with the fault address and cause latched.

## Interface
- `ADDR_WIDTH`, 22, word-address width toward CPU and SRAM
- `NUM_REGIONS`, 4, number of region descriptors (1..16)
- `CONF_BASE`, 768, word address of the descriptor table in SRAM
- `clk`  in  1  clock
- `resetn`  in  1  reset; one clock; reset is asynchronous and active-low
- `cpu_valid`  in  1  CPU request valid
- `cpu_instr`  in  1  request is an instruction fetch
- `cpu_addr`  in  ADDR_WIDTH  word address
- `cpu_wdata`  in  32  write data
- `cpu_wstrb`  in  4  byte write strobes; 0 = read
- `cpu_ready`  out  1  one-cycle completion pulse
- `cpu_rdata`  out  32  read data; valid while `cpu_ready`=1
- `inform_cpu_wait`  out  1  high while descriptors load
- `interrupt`  out  1  one-cycle fault pulse
- `fault_addr`  out  ADDR_WIDTH  address of the last fault
- `fault_cause`  out  2  0=none, 1=no region hit, 2=permission denied, 3=config lock
- `mem_wen`  out  4  SRAM byte write enables
- `mem_addr`  out  ADDR_WIDTH  SRAM word address
- `mem_wdata`  out  32  SRAM write data
- `mem_rdata`  in  32  SRAM read data, one cycle after `mem_addr`

## Operation
- Descriptor i occupies words `CONF_BASE+2i` and `CONF_BASE+2i+1`.
  - word0[ADDR_WIDTH-1:0] = base.
  - word1[ADDR_WIDTH-1:0] = limit (inclusive); [28] = enable; [29] = R; [30] = W; [31] = X.
- A region hits when enable=1 and base ≤ `cpu_addr` ≤ limit. The lowest-index hit decides. Comparisons are unsigned at full ADDR_WIDTH.
- Required permission:
  - fetch (`cpu_instr`=1): X
  - write (`cpu_wstrb`≠0): W
  - otherwise: R
- FSM states:
  - LOAD: issues table addresses `CONF_BASE..CONF_BASE+2*NUM_REGIONS-1`, one per cycle; captures `mem_rdata` one cycle later. Goes to IDLE after the last capture.
  - IDLE: on `cpu_valid`, registers the request and evaluates the check. Goes to ACCESS if permitted, otherwise FAULT.
  - ACCESS: drives `mem_addr`, `mem_wdata`, and `mem_wen`=`cpu_wstrb` (0 for reads) for one cycle, then goes to RESP.
  - RESP: `cpu_ready`=1 and `cpu_rdata`=`mem_rdata`, then returns to IDLE.
  - FAULT: `cpu_ready`=1, `cpu_rdata`=0, `interrupt`=1, `mem_wen`=0. Latches `fault_addr` and `fault_cause`, then returns to IDLE.
- `mem_wen` is nonzero only in ACCESS. A blocked write never reaches SRAM.
- `cpu_valid` in LOAD is not serviced; the request is held until IDLE.
- `fault_addr`/`fault_cause` hold their values until the next fault.
- No region enabled: every access faults with cause 1.

## Timing
- Reset values:
  - `inform_cpu_wait`=1
  - `cpu_ready`=0, `cpu_rdata`=0
  - `interrupt`=0
  - `fault_addr`=0, `fault_cause`=0
  - `mem_wen`=0, `mem_addr`=0, `mem_wdata`=0
  - all descriptors cleared (disabled)
  - state = LOAD
- Load completes 2*NUM_REGIONS+1 cycles after the first rising edge with `resetn`=1. `inform_cpu_wait` falls on that edge.
- Permitted access: `cpu_ready` rises on the 3rd edge after `cpu_valid` is sampled in IDLE.
- Faulted access: `cpu_ready` and `interrupt` rise on the 2nd edge.
- The CPU deasserts `cpu_valid` after `cpu_ready`. The block samples a new request no earlier than the cycle after RESP/FAULT.
- Reset asserted mid-access or mid-load: all outputs go to reset values immediately, any in-flight write is abandoned, and the full load repeats after release.
- Descriptor changes written to the table at run time take effect only after the next reset.

## Configuration
- `MPU_CONF_LOCK_EN`
  - Defined: any write to `CONF_BASE..CONF_BASE+2*NUM_REGIONS-1` faults with cause 3, regardless of region permissions. Reads follow the normal region rules.
  - Undefined: table words are checked like any other address.

## Test plan
Setup: NUM_REGIONS=4 with the following table.
- R0 = 0x000–0x0FF, RWX
- R1 = 0x200–0x2FF, X only
- R2 = 0x300–0x3FF, RW
- R3 = 0x080–0x0FF, R only, disabled

Scenarios:
- Release reset → `inform_cpu_wait` falls exactly 9 cycles later; a fetch issued during load is held and completes after the load finishes.
- Fetch 0x010 (mem=0x00000013) → `cpu_ready` on the 3rd edge, `cpu_rdata`=0x00000013, `interrupt`=0.
- Write 0x250, `cpu_wstrb`=0xF → `mem_wen` stays 0; `cpu_ready`+`interrupt` on the 2nd edge; `cpu_rdata`=0, `fault_addr`=0x250, `fault_cause`=2.
- Read 0x150 → fault, `fault_cause`=1. Then read 0x0FF → normal completion, `fault_addr` still 0x150.
- Write 0x0C0 with 0xA5A5A5A5 → R0 wins (R3 disabled), write succeeds; a later read returns 0xA5A5A5A5.
- With `MPU_CONF_LOCK_EN` defined: write 0x300 → fault, `fault_cause`=3. Without it: write succeeds.
